id_ex_hazard_stage: RTL and testbench
=====================================

# id_ex_hazard_stage

ID/EX pipeline register for the five-stage MIPS pipeline, merged with load-use hazard detection. It captures the decoded instruction from ID and drives the ID_EX_* fields consumed by EX, including the Rs, Rt, Rd, ALUSrc and RegWrite fields used by the forwarding unit. It inserts one-cycle bubbles on load-use hazards, squashes on branch flush and freezes on an external hold. Saturating counters report stall and flush activity.

## Interface
Parameters:
- DATA_WIDTH, 32, width of register operands and the sign-extended immediate
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears every register
- ID_Rs / ID_Rt / ID_Rd  in  5 each  decoded register addresses
- ID_ReadData1 / ID_ReadData2  in  DATA_WIDTH each  register file outputs
- ID_Imm  in  DATA_WIDTH  sign-extended immediate
- ID_ALUOp  in  3  ALU operation
- ID_ALUSrc / ID_RegDst / ID_RegWrite / ID_MemRead / ID_MemWrite / ID_MemtoReg  in  1 each  control bits
- ID_UsesRt  in  1  instruction reads Rt as a source (R-type, store, branch)
- ID_Valid  in  1  IF/ID holds a real instruction
- Flush  in  1  branch taken in EX; squash the instruction entering ID/EX
- Hold  in  1  memory busy; freeze ID/EX
- ID_EX_Rs / ID_EX_Rt / ID_EX_Rd, ID_EX_ReadData1 / ID_EX_ReadData2, ID_EX_Imm, ID_EX_ALUOp, ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Valid  out  same widths  registered stage outputs
- Stall  out  1  combinational; freezes the PC and IF/ID
- StallCount / FlushCount  out  CNT_WIDTH each  saturating statistics counters

## Operation
- Hazard is computed combinationally:
  - Hazard = ID_EX_Valid & ID_EX_MemRead & ID_Valid & (ID_EX_Rt != 0) & ((ID_EX_Rt == ID_Rs) | (ID_UsesRt & (ID_EX_Rt == ID_Rt)))
  - Stall = Hazard | Hold.
- Each rising edge, in priority order:
  1. Hold = 1: every ID_EX_* output retains its value. Flush and Hazard are ignored; upstream keeps Flush asserted until Hold drops.
  2. Flush = 1: load a bubble. FlushCount += 1.
  3. Hazard = 1: load a bubble. StallCount += 1.
  4. Otherwise: load every ID_* input into its ID_EX_* output. ID_EX_Valid takes ID_Valid.
- Bubble: all ID_EX_* outputs are 0, including data, addresses and ALUSrc. Rd = Rt = 0 guarantees the forwarding unit sees no match.
- When ID_Valid = 0 and no other condition applies, the inputs are loaded as-is. ID_EX_Valid is then 0, but the control bits are passed through unmodified; upstream must drive them to 0 for invalid instructions.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap. They are cleared only by reset.
- A bubble carries MemRead = 0, so a load-use hazard stalls for exactly one cycle. Back-to-back loads feeding each other each cause one bubble.

## Timing
- Reset (reset = 0, asynchronous): all ID_EX_* outputs are 0 and both counters are 0. Stall then equals Hold, because Hazard requires ID_EX_Valid = 1.
- Release of reset is sampled at the next rising clk edge. The first capture happens on the first edge with reset = 1.
- Latency from ID inputs to ID_EX_* outputs: 1 cycle.
- Stall responds in the same cycle as Hazard or Hold (zero latency).
- Hazard cycle N: Stall = 1 in cycle N, a bubble appears at the outputs in cycle N+1, and Hazard = 0 in cycle N+1. The stalled instruction is loaded at the end of cycle N+1.
- Flush and Hazard together: Flush wins and only FlushCount increments.
- Reset asserted mid-hold or mid-stall: clears immediately. No counter update occurs on that edge.

## Test plan
- Reset: drive random inputs with reset = 0 -> all outputs 0, counters 0, Stall = Hold; first edge after release loads the inputs.
- Pass-through: ID_Rs = 3, ID_Rt = 4, ID_Rd = 5, ID_ReadData1 = 0x1234, ID_ALUSrc = 0, ID_RegWrite = 1 -> identical values on ID_EX_* one cycle later; Stall = 0.
- Load-use: `lw $8` in ID/EX (ID_EX_MemRead = 1, ID_EX_Rt = 8), followed by `add` with ID_Rs = 8 -> Stall = 1 for exactly one cycle, then one all-zero bubble, then the add loads; StallCount = 1. Repeat with ID_Rt = 8 and ID_UsesRt = 0 -> no stall. Repeat with ID_EX_Rt = 0 -> no stall.
- Flush and hazard together: load-use condition present and Flush = 1 -> bubble; FlushCount = 1, StallCount = 0.
- Hold: assert Hold for 3 cycles with changing inputs and Flush = 1 -> outputs frozen, Stall = 1, counters unchanged. On release, the flush is applied.
- Saturation: force 2^16 + 5 hazard cycles -> StallCount = 0xFFFF, never 0.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, external hold,
// and saturating stall/flush statistics counters.
module id_ex_hazard_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            ID_Rs,
    input  logic [4:0]            ID_Rt,
    input  logic [4:0]            ID_Rd,
    input  logic [DATA_WIDTH-1:0] ID_ReadData1,
    input  logic [DATA_WIDTH-1:0] ID_ReadData2,
    input  logic [DATA_WIDTH-1:0] ID_Imm,
    input  logic [2:0]            ID_ALUOp,
    input  logic                  ID_ALUSrc,
    input  logic                  ID_RegDst,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  ID_MemWrite,
    input  logic                  ID_MemtoReg,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Valid,
    input  logic                  Flush,
    input  logic                  Hold,
    output logic [4:0]            ID_EX_Rs,
    output logic [4:0]            ID_EX_Rt,
    output logic [4:0]            ID_EX_Rd,
    output logic [DATA_WIDTH-1:0] ID_EX_ReadData1,
    output logic [DATA_WIDTH-1:0] ID_EX_ReadData2,
    output logic [DATA_WIDTH-1:0] ID_EX_Imm,
    output logic [2:0]            ID_EX_ALUOp,
    output logic                  ID_EX_ALUSrc,
    output logic                  ID_EX_RegDst,
    output logic                  ID_EX_RegWrite,
    output logic                  ID_EX_MemRead,
    output logic                  ID_EX_MemWrite,
    output logic                  ID_EX_MemtoReg,
    output logic                  ID_EX_Valid,
    output logic                  Stall,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [CNT_WIDTH-1:0]  FlushCount
);

    typedef struct packed {
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            alu_op;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  valid;
    } stage_t;

    stage_t                 stage_q, stage_d, id_stage;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
    logic                   hazard;

    always_comb begin
        id_stage = '{rs: ID_Rs, rt: ID_Rt, rd: ID_Rd,
                     rd1: ID_ReadData1, rd2: ID_ReadData2, imm: ID_Imm,
                     alu_op: ID_ALUOp, alu_src: ID_ALUSrc, reg_dst: ID_RegDst,
                     reg_write: ID_RegWrite, mem_read: ID_MemRead,
                     mem_write: ID_MemWrite, mem_to_reg: ID_MemtoReg,
                     valid: ID_Valid};
    end

    // A load in EX whose destination is a source of the instruction in ID.
    assign hazard = stage_q.valid & stage_q.mem_read & ID_Valid & (stage_q.rt != 5'd0) &
                    ((stage_q.rt == ID_Rs) | (ID_UsesRt & (stage_q.rt == ID_Rt)));
    assign Stall  = hazard | Hold;

    always_comb begin
        stage_d     = stage_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!Hold) begin
            if (Flush) begin
                stage_d = '0;
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
            end else if (hazard) begin
                stage_d = '0;
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end else begin
                stage_d = id_stage;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ID_EX_Rs        = stage_q.rs;
    assign ID_EX_Rt        = stage_q.rt;
    assign ID_EX_Rd        = stage_q.rd;
    assign ID_EX_ReadData1 = stage_q.rd1;
    assign ID_EX_ReadData2 = stage_q.rd2;
    assign ID_EX_Imm       = stage_q.imm;
    assign ID_EX_ALUOp     = stage_q.alu_op;
    assign ID_EX_ALUSrc    = stage_q.alu_src;
    assign ID_EX_RegDst    = stage_q.reg_dst;
    assign ID_EX_RegWrite  = stage_q.reg_write;
    assign ID_EX_MemRead   = stage_q.mem_read;
    assign ID_EX_MemWrite  = stage_q.mem_write;
    assign ID_EX_MemtoReg  = stage_q.mem_to_reg;
    assign ID_EX_Valid     = stage_q.valid;
    assign StallCount      = stall_cnt_q;
    assign FlushCount      = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: a vector table for the single-cycle behaviour
// plus hand-written sequences for counter saturation and asynchronous reset.
module tb_id_ex_hazard_stage;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_BUB  = 2'd1;
    localparam logic [1:0] K_HOLD = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ID_Rs, ID_Rt, ID_Rd;
    logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
    logic [2:0]    ID_ALUOp;
    logic          ID_ALUSrc, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg;
    logic          ID_UsesRt, ID_Valid, Flush, Hold;
    logic [4:0]    ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
    logic [DW-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
    logic [2:0]    ID_EX_ALUOp;
    logic          ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_RegWrite, ID_EX_MemRead;
    logic          ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Valid, Stall;
    logic [CW-1:0] StallCount, FlushCount;

    id_ex_hazard_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .ID_ALUOp(ID_ALUOp), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_UsesRt(ID_UsesRt), .ID_Valid(ID_Valid),
        .Flush(Flush), .Hold(Hold),
        .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_Imm(ID_EX_Imm), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_Valid(ID_EX_Valid),
        .Stall(Stall), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] d1;
        logic          mr, rw, as, uses, valid, flush, hold;
        logic          e_stall;
        logic [1:0]    kind;
        logic [4:0]    e_rs, e_rt, e_rd;
        logic [DW-1:0] e_d1;
        logic          e_mr, e_rw, e_as, e_valid;
        logic [CW-1:0] e_scnt, e_fcnt;
    } vec_t;

    vec_t          tbl[20];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] p_rd2, p_imm;
    logic [5:0]    p_misc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one ID instruction; the fields not under test get random values.
    task automatic drive(input logic [4:0] rs, rt, rd, input logic [DW-1:0] d1,
                         input logic mr, rw, as, uses, valid, flush, hold);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_ReadData1 = d1;
        ID_MemRead = mr; ID_RegWrite = rw; ID_ALUSrc = as; ID_UsesRt = uses;
        ID_Valid = valid; Flush = flush; Hold = hold;
        ID_ReadData2 = $urandom; ID_Imm = $urandom;
        ID_ALUOp = 3'($urandom_range(0, 7));
        ID_RegDst = 1'($urandom_range(0, 1));
        ID_MemWrite = 1'($urandom_range(0, 1));
        ID_MemtoReg = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_row(input int i);
        vec_t          v;
        logic [DW-1:0] e_rd2, e_imm;
        logic [5:0]    e_misc;
        v = tbl[i];
        drive(v.rs, v.rt, v.rd, v.d1, v.mr, v.rw, v.as, v.uses, v.valid, v.flush, v.hold);
        case (v.kind)
            K_LOAD:  begin e_rd2 = ID_ReadData2; e_imm = ID_Imm;
                           e_misc = {ID_ALUOp, ID_RegDst, ID_MemWrite, ID_MemtoReg}; end
            K_BUB:   begin e_rd2 = '0; e_imm = '0; e_misc = '0; end
            default: begin e_rd2 = p_rd2; e_imm = p_imm; e_misc = p_misc; end
        endcase
        #1;
        chk($sformatf("r%0d_stall", i), 64'(Stall), 64'(v.e_stall));
        @(posedge clk); #1;
        chk($sformatf("r%0d_addr", i), 64'({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd}),
            64'({v.e_rs, v.e_rt, v.e_rd}));
        chk($sformatf("r%0d_rd1", i), 64'(ID_EX_ReadData1), 64'(v.e_d1));
        chk($sformatf("r%0d_ctrl", i), 64'({ID_EX_MemRead, ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Valid}),
            64'({v.e_mr, v.e_rw, v.e_as, v.e_valid}));
        chk($sformatf("r%0d_rd2", i), 64'(ID_EX_ReadData2), 64'(e_rd2));
        chk($sformatf("r%0d_imm", i), 64'(ID_EX_Imm), 64'(e_imm));
        chk($sformatf("r%0d_misc", i), 64'({ID_EX_ALUOp, ID_EX_RegDst, ID_EX_MemWrite, ID_EX_MemtoReg}),
            64'(e_misc));
        chk($sformatf("r%0d_scnt", i), 64'(StallCount), 64'(v.e_scnt));
        chk($sformatf("r%0d_fcnt", i), 64'(FlushCount), 64'(v.e_fcnt));
        p_rd2 = e_rd2; p_imm = e_imm; p_misc = e_misc;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_data"}, {ID_EX_ReadData1, ID_EX_ReadData2}, 64'd0);
        chk({name, "_rest"}, 64'({ID_EX_Imm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_ALUOp,
            ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
            ID_EX_MemtoReg, ID_EX_Valid}), 64'd0);
        chk({name, "_cnts"}, 64'({StallCount, FlushCount}), 64'd0);
    endtask

    initial begin
        logic saw_zero;
        // rs rt rd d1 | mr rw as uses valid flush hold | stall kind | e_rs e_rt e_rd e_d1 | e_mr e_rw e_as e_valid | scnt fcnt
        tbl[0]  = '{3, 4, 5, 'h1234, 0,1,0,1,1,0,0, 0, K_LOAD, 3, 4, 5, 'h1234, 0,1,0,1, 0, 0};
        tbl[1]  = '{2, 8, 0, 'h100,  1,1,1,0,1,0,0, 0, K_LOAD, 2, 8, 0, 'h100,  1,1,1,1, 0, 0};
        tbl[2]  = '{8, 9, 10,'h55,   0,1,0,1,1,0,0, 1, K_BUB,  0, 0, 0, 0,      0,0,0,0, 1, 0};
        tbl[3]  = '{8, 9, 10,'h55,   0,1,0,1,1,0,0, 0, K_LOAD, 8, 9, 10,'h55,   0,1,0,1, 1, 0};
        tbl[4]  = '{1, 8, 0, 'h200,  1,1,1,0,1,0,0, 0, K_LOAD, 1, 8, 0, 'h200,  1,1,1,1, 1, 0};
        tbl[5]  = '{7, 8, 11,'h77,   0,1,1,0,1,0,0, 0, K_LOAD, 7, 8, 11,'h77,   0,1,1,1, 1, 0};
        tbl[6]  = '{1, 0, 0, 'h300,  1,1,1,0,1,0,0, 0, K_LOAD, 1, 0, 0, 'h300,  1,1,1,1, 1, 0};
        tbl[7]  = '{0, 0, 12,'h88,   0,1,0,1,1,0,0, 0, K_LOAD, 0, 0, 12,'h88,   0,1,0,1, 1, 0};
        tbl[8]  = '{1, 8, 0, 'h400,  1,1,1,0,1,0,0, 0, K_LOAD, 1, 8, 0, 'h400,  1,1,1,1, 1, 0};
        tbl[9]  = '{8, 9, 10,'h55,   0,1,0,1,1,1,0, 1, K_BUB,  0, 0, 0, 0,      0,0,0,0, 1, 1};
        tbl[10] = '{1, 8, 0, 'h500,  1,1,1,0,1,0,0, 0, K_LOAD, 1, 8, 0, 'h500,  1,1,1,1, 1, 1};
        tbl[11] = '{8, 3, 4, 'h600,  0,1,0,1,1,1,1, 1, K_HOLD, 1, 8, 0, 'h500,  1,1,1,1, 1, 1};
        tbl[12] = '{5, 6, 7, 'h700,  1,0,1,1,1,1,1, 1, K_HOLD, 1, 8, 0, 'h500,  1,1,1,1, 1, 1};
        tbl[13] = '{8, 8, 8, 'h800,  0,1,0,1,1,1,1, 1, K_HOLD, 1, 8, 0, 'h500,  1,1,1,1, 1, 1};
        tbl[14] = '{8, 3, 4, 'h900,  0,1,0,1,1,1,0, 1, K_BUB,  0, 0, 0, 0,      0,0,0,0, 1, 2};
        tbl[15] = '{3, 8, 6, 'hA00,  1,1,0,0,0,0,0, 0, K_LOAD, 3, 8, 6, 'hA00,  1,1,0,0, 1, 2};
        tbl[16] = '{8, 8, 0, 'hB00,  1,1,1,1,1,0,0, 0, K_LOAD, 8, 8, 0, 'hB00,  1,1,1,1, 1, 2};
        tbl[17] = '{8, 9, 1, 'hC00,  0,1,0,1,0,0,0, 0, K_LOAD, 8, 9, 1, 'hC00,  0,1,0,0, 1, 2};
        tbl[18] = '{1, 8, 0, 'hD00,  1,1,1,0,1,0,0, 0, K_LOAD, 1, 8, 0, 'hD00,  1,1,1,1, 1, 2};
        tbl[19] = '{4, 8, 2, 'hE00,  0,1,0,1,1,0,0, 1, K_BUB,  0, 0, 0, 0,      0,0,0,0, 2, 2};

        // Reset with random inputs: outputs cleared, Stall follows Hold only.
        reset = 1'b1;
        drive(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1, 1, 1, 1, 1, 0, 0);
        #1 reset = 1'b0;
        #2;
        chk_all_zero("rst_async");
        chk("rst_stall_hold0", 64'(Stall), 64'd0);
        @(posedge clk); #1;
        chk_all_zero("rst_edge");
        Hold = 1'b1;
        #1 chk("rst_stall_hold1", 64'(Stall), 64'd1);
        drive(6, 7, 9, 'hCAFE, 0, 1, 0, 1, 1, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_first_load", 64'({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_ReadData1}),
            64'({5'd6, 5'd7, 5'd9, 32'hCAFE}));
        chk("rst_first_valid", 64'(ID_EX_Valid), 64'd1);

        for (int i = 0; i < 20; i++) apply_row(i);

        // FlushCount saturation: a flush on every edge.
        drive(1, 2, 3, 'h1, 0, 1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 260; i++) begin
            @(posedge clk); #1;
            if (i == 99) chk("fcnt_mid", 64'(FlushCount), 64'd102);
        end
        chk("fcnt_sat", 64'(FlushCount), 64'hFF);

        // StallCount saturation: a load followed by a dependent add, repeated.
        saw_zero = 1'b0;
        for (int i = 0; i < 260; i++) begin
            drive(1, 8, 0, 'h10, 1, 1, 1, 0, 1, 0, 0);
            @(posedge clk); #1;
            drive(8, 9, 10, 'h20, 0, 1, 0, 1, 1, 0, 0);
            @(posedge clk); #1;
            if (StallCount == '0) saw_zero = 1'b1;
            if (i == 99) chk("scnt_mid", 64'(StallCount), 64'd102);
        end
        chk("scnt_sat", 64'(StallCount), 64'hFF);
        chk("scnt_never_zero", 64'(saw_zero), 64'd0);
        chk("fcnt_after_stalls", 64'(FlushCount), 64'hFF);

        // Asynchronous reset in the middle of a hold.
        drive(3, 4, 5, 'h1234, 1, 1, 0, 1, 1, 0, 0);
        @(posedge clk); #1;
        chk("pre_hold_load", 64'({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd}), 64'({5'd3, 5'd4, 5'd5}));
        drive(4, 9, 9, 'h5555, 0, 1, 0, 1, 1, 1, 1);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("rst_mid_hold");
        chk("rst_mid_stall", 64'(Stall), 64'd1);
        Hold = 1'b0;
        #1 chk("rst_no_hazard", 64'(Stall), 64'd0);
        drive(9, 10, 11, 'hABCD, 0, 1, 1, 1, 1, 0, 0);
        @(posedge clk); #1;
        chk_all_zero("rst_held_edge");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_load_addr", 64'({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_ReadData1}),
            64'({5'd9, 5'd10, 5'd11, 32'hABCD}));
        chk("rel_load_ctrl", 64'({ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Valid}), 64'b111);
        chk("rel_cnts", 64'({StallCount, FlushCount}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
